// File: rtl/fsm_pkg.sv
// Shared types and constants for the mode-controlled 64-bit pattern generator.
package fsm_pkg;

  localparam int W = 64;

  typedef enum logic [2:0] {
    LOAD,
    HOLD,
    LEFT,
    RIGHT,
    LFSR
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD,
    OP_HOLD,
    OP_ROTL,
    OP_ROTR,
    OP_LFSR
  } op_t;

  // x^64 + x^63 + x^61 + x^60 + 1, taps at bits 63, 62, 60, 59
  localparam logic [W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic lfsr_fb(input logic [W-1:0] r);
    return ^(r & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/fsm_if.sv
// Switch/seed inputs and pattern outputs of the pattern generator.
interface fsm_if;
  import fsm_pkg::*;

  logic [W-1:0] seed;
  logic         switch1;
  logic         switch2;
  logic [W-1:0] shift_seed;
  logic         out1;

  modport master (
    output seed, switch1, switch2,
    input  shift_seed, out1
  );

  modport slave (
    input  seed, switch1, switch2,
    output shift_seed, out1
  );

endinterface

// File: rtl/fsm_pattern_reg.sv
// 64-bit pattern register with load / rotate / LFSR datapath and registered serial bit.
module pattern_reg
  import fsm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  op_t          op,
  input  logic [W-1:0] seed,
  output logic [W-1:0] shift_seed,
  output logic         out1
);

  logic fb;

  always_comb begin
    fb = lfsr_fb(shift_seed);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_seed <= '0;
      out1       <= 1'b0;
    end else begin
      case (op)
        OP_LOAD: begin
          shift_seed <= seed;
          out1       <= 1'b0;
        end
        OP_ROTL: begin
          shift_seed <= {shift_seed[W-2:0], shift_seed[W-1]};
          out1       <= shift_seed[W-1];
        end
        OP_ROTR: begin
          shift_seed <= {shift_seed[0], shift_seed[W-1:1]};
          out1       <= shift_seed[0];
        end
        OP_LFSR: begin
          // all-zero is the LFSR's lock-up state, so fall back to the seed
          if (shift_seed == '0) begin
            shift_seed <= seed;
            out1       <= 1'b0;
          end else begin
            shift_seed <= {shift_seed[W-2:0], fb};
            out1       <= fb;
          end
        end
        default: begin
          out1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fsm.sv
// Two-switch mode FSM driving the pattern register; state is re-decoded from the switches every edge.
module fsm
  import fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fsm_if.slave bus
);

  state_t state;
  state_t state_next;
  op_t    op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = HOLD;
    case ({bus.switch1, bus.switch2})
      2'b10:   state_next = LEFT;
      2'b01:   state_next = RIGHT;
      2'b11:   state_next = LFSR;
      default: state_next = HOLD;
    endcase
  end

  always_comb begin
    op = OP_HOLD;
    case (state)
      LOAD:    op = OP_LOAD;
      LEFT:    op = OP_ROTL;
      RIGHT:   op = OP_ROTR;
      LFSR:    op = OP_LFSR;
      default: op = OP_HOLD;
    endcase
  end

  pattern_reg u_pattern_reg (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .seed       (bus.seed),
    .shift_seed (bus.shift_seed),
    .out1       (bus.out1)
  );

endmodule

// File: tb/tb_fsm.sv
// Randomized and directed bench for fsm against a behavioural pattern model.
module tb_fsm;
  import fsm_pkg::*;

  localparam logic [63:0] SEED = 64'h0412_6424_0034_3C28;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fsm_if bus ();

  fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model: pattern, serial bit, pending action (0 load, 1 hold, 2 left, 3 right, 4 lfsr)
  logic [63:0] m_r;
  logic        m_o;
  int          m_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic fb;
    case (m_mode)
      0: begin m_r = bus.seed; m_o = 1'b0; end
      1: m_o = 1'b0;
      2: begin m_o = m_r[63]; m_r = (m_r << 1) | (m_r >> 63); end
      3: begin m_o = m_r[0];  m_r = (m_r >> 1) | (m_r << 63); end
      default: begin
        if (m_r == 64'd0) begin
          m_r = bus.seed;
          m_o = 1'b0;
        end else begin
          fb  = m_r[63] ^ m_r[62] ^ m_r[60] ^ m_r[59];
          m_r = (m_r << 1) | {63'd0, fb};
          m_o = fb;
        end
      end
    endcase
    m_mode = bus.switch1 ? (bus.switch2 ? 4 : 2) : (bus.switch2 ? 3 : 1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " pattern"}, bus.shift_seed, m_r);
    check({tag, " out1"}, {63'd0, bus.out1}, {63'd0, m_o});
  endtask

  task automatic set_sw(input logic [1:0] s);
    bus.switch1 = s[1];
    bus.switch2 = s[0];
  endtask

  task automatic do_reset(input logic [63:0] sd, input logic [1:0] s);
    @(negedge clk);
    reset    = 1'b0;
    bus.seed = sd;
    set_sw(s);
    m_r    = '0;
    m_o    = 1'b0;
    m_mode = 0;
    #1;
    check("rst pattern", bus.shift_seed, 64'd0);
    check("rst out1", {63'd0, bus.out1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst held pattern", bus.shift_seed, 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    bus.seed = '0;
    set_sw(2'b00);

    // reset, load, hold
    do_reset(SEED, 2'b00);
    step("load");
    check("load=seed", bus.shift_seed, SEED);
    repeat (3) step("hold");
    check("hold=seed", bus.shift_seed, SEED);

    // left rotation
    do_reset(SEED, 2'b10);
    step("left load");
    step("left1");
    check("left1 const", bus.shift_seed, 64'h0824_C848_0068_7850);
    check("left1 out1", {63'd0, bus.out1}, 64'd0);
    repeat (63) step("left");
    check("left64=seed", bus.shift_seed, SEED);

    // right rotation
    do_reset(SEED, 2'b01);
    step("right load");
    step("right1");
    check("right1 const", bus.shift_seed, 64'h0209_3212_001A_1E14);
    check("right1 out1", {63'd0, bus.out1}, 64'd0);
    repeat (63) step("right");
    check("right64=seed", bus.shift_seed, SEED);

    // LFSR
    do_reset(SEED, 2'b11);
    step("lfsr load");
    step("lfsr1");
    check("lfsr1 const", bus.shift_seed, 64'h0824_C848_0068_7850);
    check("lfsr1 out1", {63'd0, bus.out1}, 64'd0);
    repeat (150) step("lfsr");

    // zero seed in LFSR stays locked at the reloaded zero
    do_reset(64'd0, 2'b11);
    repeat (5) step("lfsr zero");
    check("lfsr zero pattern", bus.shift_seed, 64'd0);
    check("lfsr zero out1", {63'd0, bus.out1}, 64'd0);

    // mode sequence with one-cycle latency, ending frozen in hold
    do_reset(SEED, 2'b00);
    step("seq load");
    set_sw(2'b10); repeat (4) step("seq left");
    set_sw(2'b11); repeat (4) step("seq lfsr");
    set_sw(2'b01); repeat (4) step("seq right");
    set_sw(2'b00); repeat (4) step("seq hold");

    // asynchronous reset in the middle of LFSR operation
    do_reset(SEED, 2'b11);
    step("mid load");
    repeat (10) step("mid lfsr");
    #2;
    reset  = 1'b0;
    m_r    = '0;
    m_o    = 1'b0;
    m_mode = 0;
    #1;
    check("mid async pattern", bus.shift_seed, 64'd0);
    check("mid async out1", {63'd0, bus.out1}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step("mid reload");
    check("mid reload=seed", bus.shift_seed, SEED);
    step("mid resume");
    check("mid resume const", bus.shift_seed, 64'h0824_C848_0068_7850);

    // random switches and seeds
    for (int unsigned run = 0; run < 4; run++) begin
      do_reset({$urandom, $urandom}, 2'($urandom_range(0, 3)));
      step("rand load");
      for (int unsigned i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) == 0) set_sw(2'($urandom_range(0, 3)));
        step("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
